// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtract controller.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtract controller, LSB first, one bit per clock through one cell.
// Optional signed overflow flag enabled by defining SERIAL_SUB_SIGNED_OVF_EN.
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_SIGNED_OVF_EN
   ,output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    sub_state_t       state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, res, res_next;
    logic             bin_q;
    logic [CW-1:0]    cnt;
    logic             cell_d, cell_bout;
    logic             last_bit;
    logic             load;

    full_subtractor_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (bin_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // New bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    always_comb begin
        res_next            = res >> 1;
        res_next[WIDTH-1]   = cell_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res        <= '0;
            bin_q      <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            overflow   <= 1'b0;
`endif
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            res   <= '0;
            bin_q <= 1'b0;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            res   <= res_next;
            bin_q <= cell_bout;
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
                diff       <= res_next;
                borrow_out <= cell_bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                // On the last bit the shifters hold the operand MSBs and cell_d is the result MSB.
                overflow   <= (a_sh[0] != b_sh[0]) && (cell_d != a_sh[0]);
`endif
            end
        end
    end

endmodule
